// File: rtl/alsu_mc.sv
// alsu_mc: multi-cycle ALSU with valid/ready handshakes on both sides.
// Legal MUL runs WIDTH shift-add steps. Every other op resolves in one EXEC cycle.
// Illegal ops return out=0 and err=1, and the leds blink until the next legal op.
// Optional feature: define ALSU_PARITY_EN to add out_par (= ^out, registered with out).
module alsu_mc #(
    parameter int    WIDTH          = 3,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON",
    parameter int    BLINK_DIV      = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    input  logic [2:0]           opcode,
    input  logic                 cin,
    input  logic                 serial_in,
    input  logic                 red_op_A,
    input  logic                 red_op_B,
    input  logic                 bypass_A,
    input  logic                 bypass_B,
    input  logic                 direction,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   out,
    output logic                 err,
`ifdef ALSU_PARITY_EN
    output logic                 out_par,
`endif
    output logic [15:0]          leds
);
    localparam int OW = 2 * WIDTH;
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [CW-1:0] M_LAST = CW'(WIDTH - 1);
    localparam logic [BW-1:0] B_LAST = BW'(BLINK_DIV - 1);
    localparam logic PRI_A = (INPUT_PRIORITY == "A");
    localparam logic FA_ON = (FULL_ADDER == "ON");

    typedef enum logic [1:0] {S_IDLE, S_EXEC, S_MUL, S_RESP} state_t;

    state_t           r_state;
    logic             r_in_ready, r_out_valid, r_err;
    logic [OW-1:0]    r_out, r_acc, r_mpl;
    logic [15:0]      r_leds;
    logic [BW-1:0]    r_bcnt;
    logic [CW-1:0]    r_mcnt;
    logic [WIDTH-1:0] r_a, r_b;
    logic [2:0]       r_op;
    logic             r_cin, r_sin, r_dir, r_red_a, r_red_b, r_byp_a, r_byp_b;
`ifdef ALSU_PARITY_EN
    logic             r_par;
`endif

    logic             w_in_byp, w_in_ill, w_in_legal, w_in_mul;
    logic             w_byp_a, w_byp_b, w_illegal, w_sel_a, w_sel_b;
    logic [WIDTH:0]   w_sum;
    logic [OW-1:0]    w_res, w_mul_next, w_a_ext;

    // Classification of the incoming bundle, used only at accept time
    assign w_in_byp   = bypass_A | bypass_B;
    assign w_in_ill   = (opcode[2:1] == 2'b11) | ((red_op_A | red_op_B) & (opcode[2:1] != 2'b00));
    assign w_in_legal = w_in_byp | ~w_in_ill;
    assign w_in_mul   = ~w_in_byp & ~w_in_ill & (opcode == 3'b011);
    assign w_a_ext    = {{WIDTH{1'b0}}, A};

    // Decisions on the latched bundle
    assign w_byp_a    = r_byp_a & (~r_byp_b | PRI_A);
    assign w_byp_b    = r_byp_b & ~w_byp_a;
    assign w_illegal  = (r_op[2:1] == 2'b11) | ((r_red_a | r_red_b) & (r_op[2:1] != 2'b00));
    assign w_sel_a    = r_red_a & (~r_red_b | PRI_A);
    assign w_sel_b    = r_red_b & ~w_sel_a;
    assign w_sum      = {1'b0, r_a} + {1'b0, r_b} + {{WIDTH{1'b0}}, r_cin & FA_ON};
    assign w_mul_next = r_acc + (r_b[0] ? r_mpl : '0);

    // Single-cycle result for the EXEC path; SHIFT/ROTATE chain off the held out value
    always_comb begin
        w_res = '0;
        if (w_byp_a)
            w_res[WIDTH-1:0] = r_a;
        else if (w_byp_b)
            w_res[WIDTH-1:0] = r_b;
        else if (!w_illegal) begin
            case (r_op)
                3'b000: begin
                    if (w_sel_a)      w_res[0] = |r_a;
                    else if (w_sel_b) w_res[0] = |r_b;
                    else              w_res[WIDTH-1:0] = r_a | r_b;
                end
                3'b001: begin
                    if (w_sel_a)      w_res[0] = ^r_a;
                    else if (w_sel_b) w_res[0] = ^r_b;
                    else              w_res[WIDTH-1:0] = r_a ^ r_b;
                end
                3'b010:  w_res[WIDTH:0] = w_sum;
                3'b100:  w_res = r_dir ? {r_out[OW-2:0], r_sin} : {r_sin, r_out[OW-1:1]};
                3'b101:  w_res = r_dir ? {r_out[OW-2:0], r_out[OW-1]} : {r_out[0], r_out[OW-1:1]};
                default: w_res = '0;
            endcase
        end
    end

    // Control FSM, result register and led blinker
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
            r_out       <= '0;
            r_err       <= 1'b0;
            r_leds      <= '0;
            r_bcnt      <= '0;
            r_mcnt      <= '0;
            r_acc       <= '0;
            r_mpl       <= '0;
            r_a         <= '0;
            r_b         <= '0;
            r_op        <= '0;
            {r_cin, r_sin, r_dir, r_red_a, r_red_b, r_byp_a, r_byp_b} <= '0;
`ifdef ALSU_PARITY_EN
            r_par       <= 1'b0;
`endif
        end else begin
            // Blink runs whenever err is held; state actions below may override it
            if (r_err) begin
                if (r_bcnt == B_LAST) begin
                    r_bcnt <= '0;
                    r_leds <= ~r_leds;
                end else begin
                    r_bcnt <= r_bcnt + 1'b1;
                end
            end
            case (r_state)
                S_IDLE: if (in_valid) begin
                    r_a        <= A;
                    r_b        <= B;
                    r_op       <= opcode;
                    {r_cin, r_sin, r_dir} <= {cin, serial_in, direction};
                    {r_red_a, r_red_b, r_byp_a, r_byp_b} <= {red_op_A, red_op_B, bypass_A, bypass_B};
                    r_acc      <= '0;
                    r_mpl      <= w_a_ext;
                    r_mcnt     <= '0;
                    r_in_ready <= 1'b0;
                    if (w_in_legal) begin
                        r_err  <= 1'b0;
                        r_leds <= '0;
                        r_bcnt <= '0;
                    end
                    r_state    <= w_in_mul ? S_MUL : S_EXEC;
                end
                S_EXEC: begin
                    r_out       <= w_res;
`ifdef ALSU_PARITY_EN
                    r_par       <= ^w_res;
`endif
                    if (w_illegal && !(r_byp_a || r_byp_b)) begin
                        r_err  <= 1'b1;
                        r_bcnt <= '0;
                    end
                    r_out_valid <= 1'b1;
                    r_state     <= S_RESP;
                end
                S_MUL: begin
                    // B is consumed LSB-first while the multiplicand walks left
                    r_acc  <= w_mul_next;
                    r_b    <= r_b >> 1;
                    r_mpl  <= r_mpl << 1;
                    r_mcnt <= r_mcnt + 1'b1;
                    if (r_mcnt == M_LAST) begin
                        r_out       <= w_mul_next;
`ifdef ALSU_PARITY_EN
                        r_par       <= ^w_mul_next;
`endif
                        r_out_valid <= 1'b1;
                        r_state     <= S_RESP;
                    end
                end
                S_RESP: if (out_ready) begin
                    r_out_valid <= 1'b0;
                    r_in_ready  <= 1'b1;
                    r_state     <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign out       = r_out;
    assign err       = r_err;
    assign leds      = r_leds;
`ifdef ALSU_PARITY_EN
    assign out_par   = r_par;
`endif
endmodule

// File: tb/tb_alsu_mc.sv
// Directed bench for alsu_mc (WIDTH=3). A second instance with INPUT_PRIORITY="B"
// shares all inputs so the priority tie-break can be compared side by side.
module tb_alsu_mc;
    localparam int W = 3;

    logic clk = 1'b0;
    logic rst;
    logic in_valid, out_ready;
    logic [W-1:0] A, B;
    logic [2:0] opcode;
    logic cin, serial_in, red_op_A, red_op_B, bypass_A, bypass_B, direction;
    logic in_ready, out_valid, err;
    logic [2*W-1:0] out;
    logic [15:0] leds;
    logic in_ready_b, out_valid_b, err_b;
    logic [2*W-1:0] out_b;
    logic [15:0] leds_b;
`ifdef ALSU_PARITY_EN
    logic par_a, par_b;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    alsu_mc #(.WIDTH(W), .INPUT_PRIORITY("A")) u_dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .direction(direction), .out_valid(out_valid), .out_ready(out_ready),
        .out(out), .err(err),
`ifdef ALSU_PARITY_EN
        .out_par(par_a),
`endif
        .leds(leds));

    alsu_mc #(.WIDTH(W), .INPUT_PRIORITY("B")) u_dut_b (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_b),
        .A(A), .B(B), .opcode(opcode), .cin(cin), .serial_in(serial_in),
        .red_op_A(red_op_A), .red_op_B(red_op_B), .bypass_A(bypass_A), .bypass_B(bypass_B),
        .direction(direction), .out_valid(out_valid_b), .out_ready(out_ready),
        .out(out_b), .err(err_b),
`ifdef ALSU_PARITY_EN
        .out_par(par_b),
`endif
        .leds(leds_b));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one bundle for exactly one edge; returns 1 time unit after the accept edge
    task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic c, input logic s, input logic d,
                        input logic ra, input logic rb, input logic ba, input logic bb);
        opcode = op; A = a; B = b; cin = c; serial_in = s; direction = d;
        red_op_A = ra; red_op_B = rb; bypass_A = ba; bypass_B = bb;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B} = '0;
    endtask

    task automatic consume();
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; A = '0; B = '0; opcode = '0;
        {cin, serial_in, direction, red_op_A, red_op_B, bypass_A, bypass_B} = '0;
        #12;
        checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
        checks++; if (out !== 6'd0) begin errors++; $display("FAIL reset_out: got %0d want 0", out); end
        checks++; if (err !== 1'b0 || leds !== 16'h0) begin errors++; $display("FAIL reset_err_leds: got %b/%h want 0/0000", err, leds); end
        rst = 1'b1;
        tick();
    endtask

    task automatic test_add();
        send(3'b010, 3'd7, 3'd7, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL add_accept: got ov=%b ir=%b want 0/0", out_valid, in_ready); end
        tick();
        checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL add_latency: got ov=%b want 1", out_valid); end
        checks++; if (out !== 6'd15 || err !== 1'b0) begin errors++; $display("FAIL add_result: got %0d err=%b want 15 err=0", out, err); end
        tick(); tick();
        checks++; if (out_valid !== 1'b1 || out !== 6'd15) begin errors++; $display("FAIL add_hold: got ov=%b out=%0d want 1/15", out_valid, out); end
        consume();
        checks++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin errors++; $display("FAIL add_handshake: got ov=%b ir=%b want 0/1", out_valid, in_ready); end
        checks++; if (out !== 6'd15) begin errors++; $display("FAIL add_out_held: got %0d want 15", out); end
        send(3'b010, 3'd5, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out !== 6'd11) begin errors++; $display("FAIL add_no_cin: got %0d want 11", out); end
        consume();
    endtask

    task automatic test_mul();
        send(3'b011, 3'd7, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 0; k < W; k++) begin
            checks++; if (out_valid !== 1'b0 || in_ready !== 1'b0) begin errors++; $display("FAIL mul_busy_%0d: got ov=%b ir=%b want 0/0", k, out_valid, in_ready); end
            tick();
        end
        checks++; if (out_valid !== 1'b1 || out !== 6'd35) begin errors++; $display("FAIL mul_result: got ov=%b out=%0d want 1/35", out_valid, out); end
        consume();
        send(3'b011, 3'd7, 3'd7, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick(); tick(); tick();
        checks++; if (out !== 6'd49) begin errors++; $display("FAIL mul_max: got %0d want 49", out); end
        consume();
    endtask

    task automatic test_illegal();
        send(3'b110, 3'd5, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out_valid !== 1'b1 || out !== 6'd0 || err !== 1'b1) begin errors++; $display("FAIL illegal_resp: got ov=%b out=%0d err=%b want 1/0/1", out_valid, out, err); end
        tick(); tick(); tick();
        checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL leds_before_toggle: got %h want 0000", leds); end
        tick();
        checks++; if (leds !== 16'hFFFF) begin errors++; $display("FAIL leds_first_toggle: got %h want ffff", leds); end
        tick(); tick(); tick(); tick();
        checks++; if (leds !== 16'h0000) begin errors++; $display("FAIL leds_second_toggle: got %h want 0000", leds); end
        consume();
        checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_persist_idle: got %b want 1", err); end
        send(3'b000, 3'd3, 3'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++; if (err !== 1'b0 || leds !== 16'h0) begin errors++; $display("FAIL legal_clears_err: got err=%b leds=%h want 0/0000", err, leds); end
        tick();
        checks++; if (out !== 6'd7) begin errors++; $display("FAIL or_result: got %0d want 7", out); end
        consume();
    endtask

    task automatic test_reduce();
        send(3'b010, 3'd3, 3'd3, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (err !== 1'b1 || out !== 6'd0) begin errors++; $display("FAIL red_add_illegal: got err=%b out=%0d want 1/0", err, out); end
        consume();
        send(3'b001, 3'd7, 3'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out !== 6'd1 || err !== 1'b0) begin errors++; $display("FAIL xor_reduce_a: got %0d err=%b want 1/0", out, err); end
        consume();
        send(3'b000, 3'd0, 3'd4, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        tick();
        checks++; if (out !== 6'd0) begin errors++; $display("FAIL or_reduce_tie_a: got %0d want 0", out); end
        checks++; if (out_b !== 6'd1) begin errors++; $display("FAIL or_reduce_tie_b: got %0d want 1", out_b); end
        consume();
        send(3'b001, 3'd5, 3'd3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out !== 6'd6) begin errors++; $display("FAIL xor_bitwise: got %0d want 6", out); end
        consume();
    endtask

    task automatic test_bypass();
        send(3'b000, 3'd3, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        tick();
        checks++; if (out !== 6'd3) begin errors++; $display("FAIL bypass_tie_a: got %0d want 3", out); end
        checks++; if (out_b !== 6'd5) begin errors++; $display("FAIL bypass_tie_b: got %0d want 5", out_b); end
        consume();
        send(3'b011, 3'd3, 3'd6, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        tick();
        checks++; if (out_valid !== 1'b1 || out !== 6'd6) begin errors++; $display("FAIL bypass_mul_exec: got ov=%b out=%0d want 1/6", out_valid, out); end
        consume();
        send(3'b111, 3'd2, 3'd1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick();
        checks++; if (out !== 6'd2 || err !== 1'b0) begin errors++; $display("FAIL bypass_over_illegal: got %0d err=%b want 2/0", out, err); end
        consume();
    endtask

    task automatic test_shift_rotate();
        send(3'b000, 3'd1, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        tick(); consume();
        send(3'b100, 3'd0, 3'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out !== 6'b000011) begin errors++; $display("FAIL shift_left: got %b want 000011", out); end
        consume();
        send(3'b101, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out !== 6'b100001) begin errors++; $display("FAIL rotate_right: got %b want 100001", out); end
        consume();
        send(3'b100, 3'd0, 3'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out !== 6'b010000) begin errors++; $display("FAIL shift_right: got %b want 010000", out); end
        consume();
        send(3'b101, 3'd0, 3'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out !== 6'b100000) begin errors++; $display("FAIL rotate_left: got %b want 100000", out); end
        consume();
    endtask

    task automatic test_reset_mid_mul();
        send(3'b011, 3'd7, 3'd5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        checks++; if (out !== 6'd0 || out_valid !== 1'b0) begin errors++; $display("FAIL mid_mul_reset: got out=%0d ov=%b want 0/0", out, out_valid); end
        rst = 1'b1;
        tick();
        checks++; if (in_ready !== 1'b1 || out_valid !== 1'b0) begin errors++; $display("FAIL after_reset_ready: got ir=%b ov=%b want 1/0", in_ready, out_valid); end
        send(3'b010, 3'd1, 3'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        tick();
        checks++; if (out !== 6'd3) begin errors++; $display("FAIL after_reset_add: got %0d want 3", out); end
        consume();
    endtask

    initial begin
        test_reset();
        test_add();
        test_mul();
        test_illegal();
        test_reduce();
        test_bypass();
        test_shift_rotate();
        test_reset_mid_mul();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
